// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared constants and types for the return-address stack
// Purpose: link offset, default depth and the address type used by the
//          ras_link_stack slice. No ports.
package ras_pkg;

  typedef logic [31:0] addr_t;

  localparam addr_t LINK_OFS      = 32'd8;
  localparam int    DEFAULT_DEPTH = 4;

endpackage

// File: rtl/ras_link_stack_if.sv
// rtl/ras_link_stack_if.sv - D-stage <-> return-address stack signal bundle
// Purpose: groups the pipeline-facing signals of ras_link_stack.
// Modports: master = pipeline side (drives Push/Pop/Resolved*),
//           slave  = stack side (drives PredPC/PredValid/Mispred/Count/Full).
// Optional: RAS_STATS_EN adds MispredCnt/PredCnt.
interface ras_link_stack_if
  import ras_pkg::*;
#(
  parameter int PTR_W = 2
);
  logic             StallD;
  logic             Clear;
  logic             Push;
  addr_t            PushPC;
  logic             Pop;
  addr_t            PredPC;
  logic             PredValid;
  logic             ResolvedValid;
  addr_t            ResolvedPC;
  logic             Mispred;
  logic [PTR_W:0]   Count;
  logic             Full;
`ifdef RAS_STATS_EN
  logic [15:0]      MispredCnt;
  logic [15:0]      PredCnt;
`endif

  modport master (
    output StallD, Clear, Push, PushPC, Pop, ResolvedValid, ResolvedPC,
`ifdef RAS_STATS_EN
    input  MispredCnt, PredCnt,
`endif
    input  PredPC, PredValid, Mispred, Count, Full
  );

  modport slave (
    input  StallD, Clear, Push, PushPC, Pop, ResolvedValid, ResolvedPC,
`ifdef RAS_STATS_EN
    output MispredCnt, PredCnt,
`endif
    output PredPC, PredValid, Mispred, Count, Full
  );

endinterface

// File: rtl/ras_ptr_ctr.sv
// rtl/ras_ptr_ctr.sv - top pointer and occupancy counter of the return-address stack
// Purpose: tracks tp (next write slot) and cnt (valid entries) for a circular
//          stack with overwrite-oldest on full and replace-top on push+pop.
// Ports: clk, reset (sync, active-low), clear, push/pop (already stall-gated);
//        tp, cnt, full, empty.
module ras_ptr_ctr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] tp,
  output logic [PTR_W:0]   cnt,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);

  // push+pop on a non-empty stack replaces the top in place: no pointer move.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      tp  <= '0;
      cnt <= '0;
    end else if (push && (!pop || empty)) begin
      tp <= tp + PTR_W'(1);
      if (!full) cnt <= cnt + (PTR_W + 1)'(1);
    end else if (pop && !push && !empty) begin
      tp  <= tp - PTR_W'(1);
      cnt <= cnt - (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/ras_link_stack.sv
// rtl/ras_link_stack.sv - return-address stack with jr $ra prediction checking
// Purpose: jal pushes PC+LINK_OFS, jr $ra pops the top as an early target;
//          the resolved target one cycle later raises a 1-cycle Mispred.
// Ports: clk, reset (sync, active-low), bus (ras_link_stack_if.slave).
// Optional: RAS_STATS_EN adds saturating MispredCnt/PredCnt (reset-only clear).
module ras_link_stack
  import ras_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  ras_link_stack_if.slave      bus
);

  logic [PTR_W-1:0] tp;
  logic [PTR_W:0]   cnt;
  logic             full;
  logic             empty;
  logic             push_g;
  logic             pop_g;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  addr_t            link_addr;
  addr_t            pred_pc;
  addr_t            stack_mem [DEPTH];
  logic             pend;
  addr_t            pend_pc;
  logic             mispred_q;
  logic             mispred_next;
  logic             pred_take;

  assign push_g    = bus.Push && !bus.StallD && !bus.Clear;
  assign pop_g     = bus.Pop  && !bus.StallD && !bus.Clear;
  assign link_addr = bus.PushPC + LINK_OFS;
  assign top_idx   = tp - PTR_W'(1);
  // Replace-top writes the current top slot; a plain push writes the free slot.
  assign wr_idx    = (pop_g && !empty) ? top_idx : tp;
  assign pred_pc   = empty ? '0 : stack_mem[top_idx];
  assign pred_take = pop_g && !empty;

  ras_ptr_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (bus.Clear),
    .push  (push_g),
    .pop   (pop_g),
    .tp    (tp),
    .cnt   (cnt),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stack_mem[i] <= '0;
    end else if (push_g) begin
      stack_mem[wr_idx] <= link_addr;
    end
  end

  assign mispred_next = bus.ResolvedValid && pend && (bus.ResolvedPC != pend_pc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend      <= 1'b0;
      pend_pc   <= '0;
      mispred_q <= 1'b0;
    end else begin
      mispred_q <= mispred_next;
      pend      <= pred_take;
      pend_pc   <= pred_pc;
    end
  end

`ifdef RAS_STATS_EN
  logic [15:0] mispred_cnt;
  logic [15:0] pred_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mispred_cnt <= '0;
      pred_cnt    <= '0;
    end else begin
      if (mispred_next && mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
      if (pred_take && pred_cnt != 16'hFFFF)       pred_cnt    <= pred_cnt + 16'd1;
    end
  end

  assign bus.MispredCnt = mispred_cnt;
  assign bus.PredCnt    = pred_cnt;
`endif

  assign bus.PredPC    = pred_pc;
  assign bus.PredValid = !empty;
  assign bus.Mispred   = mispred_q;
  assign bus.Count     = cnt;
  assign bus.Full      = full;

endmodule

// File: tb/tb_ras_link_stack.sv
// tb/tb_ras_link_stack.sv - scoreboard bench for ras_link_stack
module tb_ras_link_stack;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic [2:0]  count;
    logic        full;
    logic        mispred;
    logic [15:0] mis_cnt;
    logic [15:0] pred_cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ras_link_stack_if #(.PTR_W(2)) bus ();

  ras_link_stack #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [31:0] stk[$];
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic        m_mis;
  logic [15:0] m_mis_cnt;
  logic [15:0] m_pred_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("pred_pc",    bus.PredPC,    e.pred_pc);
    check("pred_valid", 32'(bus.PredValid), 32'(e.pred_valid));
    check("count",      32'(bus.Count),     32'(e.count));
    check("full",       32'(bus.Full),      32'(e.full));
    check("mispred",    32'(bus.Mispred),   32'(e.mispred));
`ifdef RAS_STATS_EN
    check("mispred_cnt", 32'(bus.MispredCnt), 32'(e.mis_cnt));
    check("pred_cnt",    32'(bus.PredCnt),    32'(e.pred_cnt));
`endif
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.pred_valid = (stk.size() > 0);
    e.pred_pc    = (stk.size() > 0) ? stk[$] : 32'd0;
    e.count      = 3'(stk.size());
    e.full       = (stk.size() == DEPTH);
    e.mispred    = m_mis;
    e.mis_cnt    = m_mis_cnt;
    e.pred_cnt   = m_pred_cnt;
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    bus.Push = 1'b1; bus.Pop = 1'b1; bus.PushPC = 32'h1234;
    bus.StallD = 1'b0; bus.Clear = 1'b0;
    bus.ResolvedValid = 1'b0; bus.ResolvedPC = 32'h0;
    stk.delete();
    m_pend = 1'b0; m_pend_pc = '0; m_mis = 1'b0;
    m_mis_cnt = '0; m_pred_cnt = '0;
    sb.push_back(snapshot());
    @(posedge clk); #1;
    compare_out();
    reset = 1'b1;
    bus.Push = 1'b0; bus.Pop = 1'b0;
  endtask

  task automatic step(input logic stall, input logic clr, input logic push,
                      input logic [31:0] ppc, input logic pop,
                      input logic rv, input logic [31:0] rpc);
    logic acc_push, acc_pop, nxt_pend;
    logic [31:0] nxt_pend_pc;
    bus.StallD = stall; bus.Clear = clr; bus.Push = push; bus.PushPC = ppc;
    bus.Pop = pop; bus.ResolvedValid = rv; bus.ResolvedPC = rpc;

    m_mis       = rv && m_pend && (rpc != m_pend_pc);
    acc_push    = push && !stall && !clr;
    acc_pop     = pop  && !stall && !clr;
    nxt_pend    = acc_pop && (stk.size() > 0);
    nxt_pend_pc = (stk.size() > 0) ? stk[$] : 32'd0;
    if (m_mis && m_mis_cnt != 16'hFFFF) m_mis_cnt++;
    if (nxt_pend && m_pred_cnt != 16'hFFFF) m_pred_cnt++;

    if (clr) stk.delete();
    else if (acc_push && acc_pop && stk.size() > 0) stk[$] = ppc + 32'd8;
    else if (acc_push) begin
      stk.push_back(ppc + 32'd8);
      if (stk.size() > DEPTH) void'(stk.pop_front());
    end else if (acc_pop && stk.size() > 0) void'(stk.pop_back());

    m_pend    = nxt_pend;
    m_pend_pc = nxt_pend_pc;
    sb.push_back(snapshot());
    @(posedge clk); #1;
    compare_out();
  endtask

  task automatic push_pc(input logic [31:0] pc);
    step(0, 0, 1, pc, 0, 0, 32'h0);
  endtask

  task automatic pop1();
    step(0, 0, 0, 32'h0, 1, 0, 32'h0);
  endtask

  task automatic idle(input logic rv, input logic [31:0] rpc);
    step(0, 0, 0, 32'h0, 0, rv, rpc);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus.StallD = 0; bus.Clear = 0; bus.Push = 0; bus.PushPC = 0;
    bus.Pop = 0; bus.ResolvedValid = 0; bus.ResolvedPC = 0;
    @(posedge clk); #1;

    do_reset();
    check("reset_count_const", 32'(bus.Count), 32'd0);

    push_pc(32'h3000); push_pc(32'h3010); push_pc(32'h3020);
    check("three_push_top", bus.PredPC, 32'h3028);
    pop1(); pop1(); pop1();

    for (int i = 0; i < 5; i++) push_pc(32'h100 + 32'(i) * 32'h10);
    check("wrap_full", 32'(bus.Full), 32'd1);
    for (int i = 0; i < 4; i++) pop1();
    pop1();
    check("empty_pop_count", 32'(bus.Count), 32'd0);

    push_pc(32'h3000);
    step(0, 0, 1, 32'h4000, 1, 0, 32'h0);
    check("replace_top", bus.PredPC, 32'h4008);
    step(0, 1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h4000, 1, 0, 32'h0);
    check("replace_empty_count", 32'(bus.Count), 32'd1);

    step(1, 0, 1, 32'h7000, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 1, 1, 32'h7000, 0, 0, 32'h0);
    check("clear_push_count", 32'(bus.Count), 32'd0);

    do_reset();
    push_pc(32'h3000);
    pop1();
    idle(1, 32'h3008);
    idle(0, 32'h0);
    push_pc(32'h3000);
    pop1();
    idle(1, 32'h5000);
    check("mispred_pulse", 32'(bus.Mispred), 32'd1);
    idle(0, 32'h0);
    idle(1, 32'h5000);
`ifdef RAS_STATS_EN
    check("pred_cnt_final", 32'(bus.PredCnt), 32'd2);
    check("mispred_cnt_final", 32'(bus.MispredCnt), 32'd1);
`endif

    for (int i = 0; i < 6; i++) push_pc(32'hFFFF_FFF8 + 32'(i));
    for (int i = 0; i < 5; i++) pop1();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
